mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback formatter for the multi-cycle pipelined MIPS core. Captures memory-stage results on the rising edge, extracts and extends load data, and selects the writeback source (ALU, load, link). Drives the register file write port (writeReg/writeData/regWrite) and the forwarding network, and counts retired instructions. The register file commits on the falling edge, so a value captured here is written in the same cycle.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
REG_W, 5, register index width.
CNT_W, 32, retired-instruction counter width.

Ports:
clock_in  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high
stall  input  1  hold all stage state
flush  input  1  kill stage contents (bubble)
mem_valid  input  1  MEM stage holds a real instruction
mem_regWrite  input  1  instruction writes a register
mem_memToReg  input  1  writeback source is load data
mem_link  input  1  writeback source is link address (jal/jalr)
mem_loadType  input  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5-7 treated as lw
mem_addrLow  input  2  effective address bits [1:0]
mem_aluResult  input  DATA_W  ALU result
mem_readData  input  DATA_W  raw data-memory word
mem_pcPlus4  input  DATA_W  PC+4 of the instruction
mem_writeReg  input  REG_W  destination register index
wb_valid  output  1  stage holds a real instruction
writeReg  output  REG_W  register file write index
writeData  output  DATA_W  register file write data
regWrite  output  1  register file write enable
retireCount  output  CNT_W  retired-instruction count

Behaviour:
- Reset, on the rising edge with reset=1: wb_valid, regWrite, writeReg, writeData and retireCount all become 0. Reset has priority over everything else.
- Update priority on each rising edge: reset > flush > stall > capture.
- flush=1: wb_valid=0 and regWrite=0; writeReg=0 and writeData=0; retireCount unchanged. flush wins over a simultaneous stall.
- stall=1 (no flush): all outputs hold; retireCount unchanged.
- Capture (no reset/flush/stall):
  - wb_valid <= mem_valid.
  - writeReg <= mem_writeReg.
  - regWrite <= mem_valid & mem_regWrite & (mem_writeReg != 0). Writes to $0 are always suppressed.
  - writeData <= the selected source, even when regWrite=0.
  - retireCount increments by 1 if mem_valid=1; it wraps modulo 2^CNT_W.
- Source select, priority order:
  - mem_link: mem_pcPlus4 + 4 (32-bit, wraps).
  - else mem_memToReg: formatted load data.
  - else mem_aluResult.
- Load formatting is big-endian:
  - Byte lanes: addrLow 0 selects [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
  - Halfword: addrLow[1]=0 selects [31:16]; addrLow[1]=1 selects [15:0]. addrLow[0] is ignored; there is no alignment trap.
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - lw passes the full word and ignores addrLow.
- Latency: one cycle from MEM inputs to outputs. Outputs come straight from registers, with no combinational path from inputs.
- Reset asserted mid-stall or mid-flush still clears everything on that edge.

Test Plan:
- Reset then ALU op: reset=1 for 2 cycles → all outputs 0. Then apply mem_valid=1, regWrite=1, writeReg=8, aluResult=0x1234_5678 → next edge: regWrite=1, writeReg=8, writeData=0x12345678, retireCount=1.
- Loads with readData=0x80FF_7F01:
  - lb, addrLow=0 → 0xFFFFFF80.
  - lbu, addrLow=0 → 0x00000080.
  - lb, addrLow=2 → 0x0000007F.
  - lh, addrLow=2 → 0x00007F01.
  - lhu, addrLow=0 → 0x000080FF.
  - lw, addrLow=3 → 0x80FF7F01.
- jal: link=1, memToReg=1, pcPlus4=0x0040_0010, writeReg=31 → writeData=0x00400014, regWrite=1. Same instruction with writeReg=0 → regWrite=0, retireCount still increments.
- Stall and flush:
  - Capture instruction A, then stall=1 for 3 cycles while inputs change → outputs hold A and retireCount is unchanged.
  - flush=1 together with stall=1 → wb_valid=0, regWrite=0, writeData=0.
  - mem_valid=0 capture → regWrite=0 and no count increment.
- Counter wrap: run with CNT_W=4 and 17 valid captures → retireCount=1.
- Reset during stall: stall=1, reset=1 → all outputs 0 on that edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback formatter.
// Captures memory-stage results, extracts and extends big-endian load data,
// selects the writeback source (ALU, load, link) and counts retired
// instructions. Outputs come straight from registers, so the register file
// (which commits on the falling edge) sees them within the same cycle.
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clock_in,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              mem_valid,
   input  logic              mem_regWrite,
   input  logic              mem_memToReg,
   input  logic              mem_link,
   input  logic [2:0]        mem_loadType,
   input  logic [1:0]        mem_addrLow,
   input  logic [DATA_W-1:0] mem_aluResult,
   input  logic [DATA_W-1:0] mem_readData,
   input  logic [DATA_W-1:0] mem_pcPlus4,
   input  logic [REG_W-1:0]  mem_writeReg,
   output logic              wb_valid,
   output logic [REG_W-1:0]  writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic              regWrite,
   output logic [CNT_W-1:0]  retireCount
);

   // Load type encodings; anything not listed behaves as a full-word load.
   typedef enum logic [2:0] {
      LOAD_LW  = 3'd0,
      LOAD_LB  = 3'd1,
      LOAD_LBU = 3'd2,
      LOAD_LH  = 3'd3,
      LOAD_LHU = 3'd4
   } loadTypeT;

   logic [7:0]        byteLane;
   logic [15:0]       halfLane;
   logic [DATA_W-1:0] loadData;
   logic [DATA_W-1:0] wbSource;
   logic              captureRegWrite;
   loadTypeT          loadKind;

   assign loadKind = loadTypeT'(mem_loadType);

   // Pick the byte and halfword lanes; the address is big-endian, so lane 0 is the MSB end.
   always_comb begin
      byteLane = mem_readData[31:24];
      case (mem_addrLow)
         2'd0:    byteLane = mem_readData[31:24];
         2'd1:    byteLane = mem_readData[23:16];
         2'd2:    byteLane = mem_readData[15:8];
         default: byteLane = mem_readData[7:0];
      endcase
      halfLane = mem_addrLow[1] ? mem_readData[15:0] : mem_readData[31:16];
   end

   // Extend the selected lane according to the load type; full-word loads ignore the address.
   always_comb begin
      loadData = mem_readData;
      case (loadKind)
         LOAD_LB:  loadData = {{(DATA_W-8){byteLane[7]}}, byteLane};
         LOAD_LBU: loadData = {{(DATA_W-8){1'b0}}, byteLane};
         LOAD_LH:  loadData = {{(DATA_W-16){halfLane[15]}}, halfLane};
         LOAD_LHU: loadData = {{(DATA_W-16){1'b0}}, halfLane};
         default:  loadData = mem_readData;
      endcase
   end

   // Writeback source priority: link address, then load data, then ALU result.
   always_comb begin
      wbSource = mem_aluResult;
      if (mem_link) begin
         wbSource = mem_pcPlus4 + DATA_W'(4);
      end else if (mem_memToReg) begin
         wbSource = loadData;
      end
   end

   // Writes to register zero are never committed.
   assign captureRegWrite = mem_valid & mem_regWrite & (mem_writeReg != '0);

   // Stage register: reset beats flush, flush beats stall, otherwise capture the MEM results.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         wb_valid    <= 1'b0;
         regWrite    <= 1'b0;
         writeReg    <= '0;
         writeData   <= '0;
         retireCount <= '0;
      end else if (flush) begin
         wb_valid  <= 1'b0;
         regWrite  <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
      end else if (!stall) begin
         wb_valid  <= mem_valid;
         regWrite  <= captureRegWrite;
         writeReg  <= mem_writeReg;
         writeData <= wbSource;
         if (mem_valid) begin
            retireCount <= retireCount + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver applies directed and random
// stimulus and pushes the expected register state computed by a behavioural
// model; a monitor pops and compares after every rising edge. A second
// instance with a 4-bit counter exercises the retire-count wrap.
module tb_mem_wb_stage;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        memValid;
   logic        memRegWrite;
   logic        memMemToReg;
   logic        memLink;
   logic [2:0]  memLoadType;
   logic [1:0]  memAddrLow;
   logic [31:0] memAluResult;
   logic [31:0] memReadData;
   logic [31:0] memPcPlus4;
   logic [4:0]  memWriteReg;

   logic        wbValid;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic        regWrite;
   logic [31:0] retireCount;

   logic        smallWbValid;
   logic [4:0]  smallWriteReg;
   logic [31:0] smallWriteData;
   logic        smallRegWrite;
   logic [3:0]  smallRetireCount;

   typedef struct {
      logic        reset;
      logic        stall;
      logic        flush;
      logic        valid;
      logic        regWrite;
      logic        memToReg;
      logic        link;
      logic [2:0]  loadType;
      logic [1:0]  addrLow;
      logic [31:0] aluResult;
      logic [31:0] readData;
      logic [31:0] pcPlus4;
      logic [4:0]  writeReg;
   } stimT;

   typedef struct {
      logic        valid;
      logic [4:0]  writeReg;
      logic [31:0] writeData;
      logic        regWrite;
      longint      count;
   } stateT;

   stateT expQ[$];
   stateT model;
   int    checkCount = 0;
   int    passCount  = 0;

   mem_wb_stage #(.DATA_W(32), .REG_W(5), .CNT_W(32)) dut (
      .clock_in(clock), .reset(reset), .stall(stall), .flush(flush),
      .mem_valid(memValid), .mem_regWrite(memRegWrite), .mem_memToReg(memMemToReg),
      .mem_link(memLink), .mem_loadType(memLoadType), .mem_addrLow(memAddrLow),
      .mem_aluResult(memAluResult), .mem_readData(memReadData), .mem_pcPlus4(memPcPlus4),
      .mem_writeReg(memWriteReg), .wb_valid(wbValid), .writeReg(writeReg),
      .writeData(writeData), .regWrite(regWrite), .retireCount(retireCount)
   );

   mem_wb_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dutSmall (
      .clock_in(clock), .reset(reset), .stall(stall), .flush(flush),
      .mem_valid(memValid), .mem_regWrite(memRegWrite), .mem_memToReg(memMemToReg),
      .mem_link(memLink), .mem_loadType(memLoadType), .mem_addrLow(memAddrLow),
      .mem_aluResult(memAluResult), .mem_readData(memReadData), .mem_pcPlus4(memPcPlus4),
      .mem_writeReg(memWriteReg), .wb_valid(smallWbValid), .writeReg(smallWriteReg),
      .writeData(smallWriteData), .regWrite(smallRegWrite), .retireCount(smallRetireCount)
   );

   // Free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference load formatting from the big-endian lane rules, using plain arithmetic
   function automatic logic [31:0] formatLoad(input logic [2:0] kind, input logic [1:0] addr,
                                              input logic [31:0] word);
      longint w = longint'(word);
      longint a = longint'(addr);
      longint v;
      case (kind)
         3'd1, 3'd2: begin
            v = (w >> (8 * (3 - a))) % 256;
            if (kind == 3'd1 && v >= 128) v = v - 256;
         end
         3'd3, 3'd4: begin
            v = (w >> ((a >= 2) ? 0 : 16)) % 65536;
            if (kind == 3'd3 && v >= 32768) v = v - 65536;
         end
         default: v = w;
      endcase
      return 32'(v);
   endfunction

   // Advance the behavioural model by one rising edge
   function automatic stateT stepModel(input stateT cur, input stimT s);
      stateT nxt = cur;
      longint src;
      if (s.reset) begin
         nxt.valid = 0; nxt.writeReg = 0; nxt.writeData = 0; nxt.regWrite = 0; nxt.count = 0;
      end else if (s.flush) begin
         nxt.valid = 0; nxt.writeReg = 0; nxt.writeData = 0; nxt.regWrite = 0;
      end else if (!s.stall) begin
         if (s.link) src = (longint'(s.pcPlus4) + 4) % 64'h1_0000_0000;
         else if (s.memToReg) src = longint'(formatLoad(s.loadType, s.addrLow, s.readData));
         else src = longint'(s.aluResult);
         nxt.valid     = s.valid;
         nxt.writeReg  = s.writeReg;
         nxt.writeData = 32'(src);
         nxt.regWrite  = s.valid && s.regWrite && (s.writeReg != 0);
         if (s.valid) nxt.count = cur.count + 1;
      end
      return nxt;
   endfunction

   // Drive one cycle of inputs and push the expected post-edge state
   task automatic applyStimulus(input stimT s);
      @(negedge clock);
      reset = s.reset; stall = s.stall; flush = s.flush;
      memValid = s.valid; memRegWrite = s.regWrite; memMemToReg = s.memToReg;
      memLink = s.link; memLoadType = s.loadType; memAddrLow = s.addrLow;
      memAluResult = s.aluResult; memReadData = s.readData; memPcPlus4 = s.pcPlus4;
      memWriteReg = s.writeReg;
      model = stepModel(model, s);
      expQ.push_back(model);
   endtask

   task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic checkOutput(input stateT e);
      compareField("wb_valid", 32'(wbValid), 32'(e.valid));
      compareField("writeReg", 32'(writeReg), 32'(e.writeReg));
      compareField("writeData", writeData, e.writeData);
      compareField("regWrite", 32'(regWrite), 32'(e.regWrite));
      compareField("retireCount", retireCount, 32'(e.count % 64'h1_0000_0000));
      compareField("retireCount4", 32'(smallRetireCount), 32'(e.count % 16));
   endtask

   // Monitor: after each rising edge, compare the DUT registers against the oldest expectation
   initial begin
      stateT e;
      forever begin
         @(posedge clock);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   function automatic stimT idleStim();
      stimT s;
      s.reset = 0; s.stall = 0; s.flush = 0; s.valid = 0; s.regWrite = 0;
      s.memToReg = 0; s.link = 0; s.loadType = 0; s.addrLow = 0;
      s.aluResult = 0; s.readData = 0; s.pcPlus4 = 0; s.writeReg = 0;
      return s;
   endfunction

   function automatic stimT randomStim();
      stimT s;
      s.reset     = ($urandom_range(0, 49) == 0);
      s.flush     = ($urandom_range(0, 9) == 0);
      s.stall     = ($urandom_range(0, 4) == 0);
      s.valid     = ($urandom_range(0, 3) != 0);
      s.regWrite  = ($urandom_range(0, 3) != 0);
      s.memToReg  = $urandom_range(0, 1) == 1;
      s.link      = ($urandom_range(0, 5) == 0);
      s.loadType  = 3'($urandom_range(0, 7));
      s.addrLow   = 2'($urandom_range(0, 3));
      s.aluResult = $urandom();
      s.readData  = $urandom();
      s.pcPlus4   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom();
      s.writeReg  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      return s;
   endfunction

   // Stimulus: directed scenarios first, then a randomized run
   initial begin
      stimT s;
      int   waitCycles;
      model = '{valid: 0, writeReg: 0, writeData: 0, regWrite: 0, count: 0};
      reset = 1; stall = 0; flush = 0; memValid = 0; memRegWrite = 0; memMemToReg = 0;
      memLink = 0; memLoadType = 0; memAddrLow = 0; memAluResult = 0; memReadData = 0;
      memPcPlus4 = 0; memWriteReg = 0;

      s = idleStim(); s.reset = 1;
      applyStimulus(s);
      applyStimulus(s);

      s = idleStim(); s.valid = 1; s.regWrite = 1; s.writeReg = 8; s.aluResult = 32'h1234_5678;
      applyStimulus(s);

      for (int i = 0; i < 6; i++) begin
         logic [2:0] kinds [6] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd0};
         logic [1:0] addrs [6] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3};
         s = idleStim(); s.valid = 1; s.regWrite = 1; s.memToReg = 1; s.writeReg = 5'(9 + i);
         s.readData = 32'h80FF_7F01; s.loadType = kinds[i]; s.addrLow = addrs[i];
         s.aluResult = 32'hDEAD_BEEF;
         applyStimulus(s);
      end

      s = idleStim(); s.valid = 1; s.regWrite = 1; s.link = 1; s.memToReg = 1;
      s.pcPlus4 = 32'h0040_0010; s.writeReg = 31;
      applyStimulus(s);
      s.writeReg = 0;
      applyStimulus(s);

      s = idleStim(); s.valid = 1; s.regWrite = 1; s.writeReg = 5; s.aluResult = 32'hA5A5_0001;
      applyStimulus(s);
      for (int i = 0; i < 3; i++) begin
         s = idleStim(); s.stall = 1; s.valid = 1; s.regWrite = 1;
         s.writeReg = 5'(20 + i); s.aluResult = $urandom();
         applyStimulus(s);
      end
      s = idleStim(); s.stall = 1; s.flush = 1; s.valid = 1; s.regWrite = 1;
      s.writeReg = 7; s.aluResult = 32'h1111_2222;
      applyStimulus(s);
      s = idleStim(); s.valid = 0; s.regWrite = 1; s.writeReg = 3; s.aluResult = 32'h3333_4444;
      applyStimulus(s);

      s = idleStim(); s.reset = 1;
      applyStimulus(s);
      for (int i = 0; i < 17; i++) begin
         s = idleStim(); s.valid = 1; s.regWrite = 1; s.writeReg = 5'(i); s.aluResult = 32'(i * 3);
         applyStimulus(s);
      end

      s = idleStim(); s.stall = 1; s.reset = 1; s.valid = 1; s.regWrite = 1; s.writeReg = 4;
      applyStimulus(s);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(randomStim());
      end

      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 20) begin
         @(posedge clock);
         waitCycles++;
      end
      #3;
      if (expQ.size() > 0) begin
         checkCount++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
